// File: rtl/uart_param_core.sv
// uart_param_core: parametrised UART transceiver with loopback and FWFT receive FIFO
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   baud_sel       divisor select (0: CLKS_PER_BIT_0, 1: CLKS_PER_BIT_1), latched per frame
//   loopback       1 = receiver listens to the internal tx line
//   tx_start       send request, honoured when tx_busy=0
//   tx_data        payload captured on acceptance
//   tx_busy        transmitter active
//   tx             serial output, idle high
//   rx             serial input, asynchronous
//   rx_data        FIFO head (0 when empty)
//   rx_valid       FIFO not empty
//   rx_rd          pop FIFO head
//   rx_count       FIFO occupancy
//   parity_error   parity result of the last completed frame
//   stop_bit_error stop-bit result of the last completed frame
//   overrun        sticky frame-dropped flag, cleared by an accepted rx_rd
//   baud_rate      one-hot divisor indicator for LEDs
module uart_param_core #(
    parameter int DATA_BITS      = 8,
    parameter int PARITY_EN      = 1,
    parameter int PARITY_ODD     = 0,
    parameter int STOP_BITS      = 1,
    parameter int CLKS_PER_BIT_0 = 5208,
    parameter int CLKS_PER_BIT_1 = 434,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          baud_sel,
    input  logic                          loopback,
    input  logic                          tx_start,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_busy,
    output logic                          tx,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_rd,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          parity_error,
    output logic                          stop_bit_error,
    output logic                          overrun,
    output logic [1:0]                    baud_rate
);
    localparam int CMAX = (CLKS_PER_BIT_0 > CLKS_PER_BIT_1) ? CLKS_PER_BIT_0 : CLKS_PER_BIT_1;
    localparam int CW   = $clog2(CMAX);
    localparam int AW   = $clog2(FIFO_DEPTH);
    // Divisors are stored as N-1 so the bit counter compares directly against them.
    localparam logic [CW-1:0] L0 = CW'(CLKS_PER_BIT_0 - 1);
    localparam logic [CW-1:0] L1 = CW'(CLKS_PER_BIT_1 - 1);
    localparam logic P_ODD = (PARITY_ODD != 0);
    localparam logic P_EN  = (PARITY_EN != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    assign baud_rate = baud_sel ? 2'b10 : 2'b01;

    state_t               r_tx_st, w_tx_nx;
    logic [CW-1:0]        r_tx_last, r_tx_cnt;
    logic [3:0]           r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_sh;
    logic                 r_tx_par;
    logic                 w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == r_tx_last);

    always_comb begin
        w_tx_nx = r_tx_st;
        case (r_tx_st)
            IDLE:    if (tx_start) w_tx_nx = START;
            START:   if (w_tx_tick) w_tx_nx = DATA;
            DATA:    if (w_tx_tick && r_tx_idx == 4'(DATA_BITS - 1)) w_tx_nx = P_EN ? PARITY : STOP;
            PARITY:  if (w_tx_tick) w_tx_nx = STOP;
            STOP:    if (w_tx_tick && r_tx_idx == 4'(STOP_BITS - 1)) w_tx_nx = IDLE;
            default: w_tx_nx = IDLE;
        endcase
        tx_busy = (r_tx_st != IDLE);
        tx = (r_tx_st == START)  ? 1'b0 :
             (r_tx_st == DATA)   ? r_tx_sh[0] :
             (r_tx_st == PARITY) ? r_tx_par : 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_st   <= IDLE;
            r_tx_last <= '0;
            r_tx_cnt  <= '0;
            r_tx_idx  <= '0;
            r_tx_sh   <= '0;
            r_tx_par  <= 1'b0;
        end else begin
            r_tx_st <= w_tx_nx;
            if (r_tx_st == IDLE && tx_start) begin
                r_tx_last <= baud_sel ? L1 : L0;
                r_tx_cnt  <= '0;
                r_tx_idx  <= '0;
                r_tx_sh   <= tx_data;
                r_tx_par  <= ^tx_data ^ P_ODD;
            end else if (r_tx_st != IDLE) begin
                r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + 1'b1;
                if (w_tx_tick) begin
                    r_tx_idx <= (w_tx_nx != r_tx_st) ? 4'd0 : r_tx_idx + 4'd1;
                    if (r_tx_st == DATA) r_tx_sh <= r_tx_sh >> 1;
                end
            end
        end
    end

    logic r_s1, r_s2, r_prev, r_lb;
    logic w_line;

    // Loopback selection only changes while the receiver is idle.
    assign w_line = r_lb ? tx : rx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
            r_lb   <= 1'b0;
        end else begin
            r_s1   <= w_line;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_lb   <= (r_rx_st == IDLE) ? loopback : r_lb;
        end
    end

    state_t               r_rx_st, w_rx_nx;
    logic [CW-1:0]        r_rx_last, r_rx_cnt;
    logic [3:0]           r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_sh;
    logic                 r_rx_pbit;
    logic                 w_rx_tick, w_rx_done;

    // START waits half a bit (N/2-1 == (N-1)>>1 for even N), later bits a full bit.
    assign w_rx_tick = (r_rx_st == START) ? (r_rx_cnt == (r_rx_last >> 1)) : (r_rx_cnt == r_rx_last);
    assign w_rx_done = (r_rx_st == STOP) && w_rx_tick;

    always_comb begin
        w_rx_nx = r_rx_st;
        case (r_rx_st)
            IDLE:    if (r_prev && !r_s2) w_rx_nx = START;
            START:   if (w_rx_tick) w_rx_nx = r_s2 ? IDLE : DATA;
            DATA:    if (w_rx_tick && r_rx_idx == 4'(DATA_BITS - 1)) w_rx_nx = P_EN ? PARITY : STOP;
            PARITY:  if (w_rx_tick) w_rx_nx = STOP;
            STOP:    if (w_rx_tick) w_rx_nx = IDLE;
            default: w_rx_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_st        <= IDLE;
            r_rx_last      <= '0;
            r_rx_cnt       <= '0;
            r_rx_idx       <= '0;
            r_rx_sh        <= '0;
            r_rx_pbit      <= 1'b0;
            parity_error   <= 1'b0;
            stop_bit_error <= 1'b0;
        end else begin
            r_rx_st <= w_rx_nx;
            if (r_rx_st == IDLE) begin
                r_rx_last <= baud_sel ? L1 : L0;
                r_rx_cnt  <= '0;
                r_rx_idx  <= '0;
            end else begin
                r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + 1'b1;
                if (w_rx_tick) begin
                    r_rx_idx <= (w_rx_nx != r_rx_st) ? 4'd0 : r_rx_idx + 4'd1;
                    if (r_rx_st == DATA) r_rx_sh <= {r_s2, r_rx_sh[DATA_BITS-1:1]};
                    if (r_rx_st == PARITY) r_rx_pbit <= r_s2;
                end
            end
            if (w_rx_done) begin
                parity_error   <= P_EN & (^r_rx_sh ^ r_rx_pbit ^ P_ODD);
                stop_bit_error <= ~r_s2;
            end
        end
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wp, r_rp;
    logic [AW:0]          r_cnt;
    logic                 w_rd, w_full, w_wr;

    assign w_rd     = rx_rd && (r_cnt != '0);
    assign w_full   = (r_cnt == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still takes the frame.
    assign w_wr     = w_rx_done && (!w_full || w_rd);
    assign rx_valid = (r_cnt != '0);
    assign rx_count = r_cnt;
    assign rx_data  = rx_valid ? r_mem[r_rp] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            overrun <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_cnt   <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
            overrun <= w_rd ? 1'b0 : (w_rx_done && w_full) ? 1'b1 : overrun;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wp] <= r_rx_sh;
    end
endmodule

// File: tb/tb_uart_param_core.sv
// tb_uart_param_core: directed self-checking bench for uart_param_core (N=16 at baud_sel=1, 4-entry FIFO)
module tb_uart_param_core;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_sel = 1'b1;
    logic       loopback = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       rx = 1'b1;
    logic       rx_rd = 1'b0;
    logic       tx_busy, tx, rx_valid, parity_error, stop_bit_error, overrun;
    logic [7:0] rx_data;
    logic [2:0] rx_count;
    logic [1:0] baud_rate;
    int         n_checks = 0;
    int         n_fail = 0;
    int         busy;
    logic [10:0] bits;

    always #5 clock = ~clock;

    uart_param_core #(.CLKS_PER_BIT_1(16), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .baud_sel(baud_sel), .loopback(loopback),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx(tx), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd), .rx_count(rx_count),
        .parity_error(parity_error), .stop_bit_error(stop_bit_error), .overrun(overrun),
        .baud_rate(baud_rate)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        step(1);
        rx_rd = 1'b0;
    endtask

    // Counts busy cycles and captures tx at the middle of each of the 11 bit periods.
    task automatic send_tx(input logic [7:0] d, output int nb, output logic [10:0] b);
        nb = 0;
        b = '0;
        tx_data = d;
        tx_start = 1'b1;
        step(1);
        tx_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (!tx_busy) break;
            if (i % 16 == 8 && i / 16 < 11) b[i/16] = tx;
            nb++;
        end
        step(1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic pflip, input logic stop);
        rx = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(16);
        end
        rx = ^d ^ pflip;
        step(16);
        rx = stop;
        step(16);
        rx = 1'b1;
        step(20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_count", rx_count, 0);
        check("rst_data", rx_data, 0);
        check("rst_flags", {parity_error, stop_bit_error, overrun}, 0);
        check("baud_rate_1", baud_rate, 2'b10);
        baud_sel = 1'b0;
        #1;
        check("baud_rate_0", baud_rate, 2'b01);
        baud_sel = 1'b1;
        reset_n = 1'b1;
        step(5);

        send_tx(8'hA5, busy, bits);
        check("lb_busy_len", busy, 176);
        check("lb_tx_bits", bits, {1'b1, 1'b0, 8'hA5, 1'b0});
        step(2);
        check("lb_valid", rx_valid, 1);
        check("lb_data", rx_data, 8'hA5);
        check("lb_flags", {parity_error, stop_bit_error}, 0);
        check("lb_count", rx_count, 1);
        pop();
        check("lb_pop_count", rx_count, 0);
        check("lb_pop_valid", rx_valid, 0);

        loopback = 1'b0;
        step(4);
        send_rx(8'h3C, 1'b1, 1'b1);
        check("par_err_set", parity_error, 1);
        check("par_err_stop", stop_bit_error, 0);
        check("par_err_data", rx_data, 8'h3C);
        pop();
        send_rx(8'h5A, 1'b0, 1'b1);
        check("par_err_clr", parity_error, 0);
        check("par_clr_data", rx_data, 8'h5A);
        pop();

        send_rx(8'h12, 1'b0, 1'b0);
        check("stop_err_set", stop_bit_error, 1);
        check("stop_err_data", rx_data, 8'h12);
        pop();
        send_rx(8'h81, 1'b0, 1'b1);
        check("stop_err_clr", stop_bit_error, 0);
        check("stop_clr_data", rx_data, 8'h81);
        pop();
        check("empty_before_ovr", rx_count, 0);

        for (int i = 1; i <= 9; i++) send_rx(8'(i), 1'b0, 1'b1);
        check("ovr_count", rx_count, 4);
        check("ovr_flag", overrun, 1);
        check("ovr_head0", rx_data, 8'h01);
        pop();
        check("ovr_clr", overrun, 0);
        check("ovr_count3", rx_count, 3);
        check("ovr_head1", rx_data, 8'h02);
        pop();
        check("ovr_head2", rx_data, 8'h03);
        pop();
        check("ovr_head3", rx_data, 8'h04);
        pop();
        check("ovr_drained", rx_count, 0);

        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(60);
        check("glitch_valid", rx_valid, 0);
        check("glitch_count", rx_count, 0);
        check("glitch_flags", {parity_error, stop_bit_error, overrun}, 0);

        send_rx(8'h66, 1'b0, 1'b1);
        check("pre_rst_count", rx_count, 1);
        tx_data = 8'h33;
        tx_start = 1'b1;
        step(1);
        tx_start = 1'b0;
        step(60);
        check("mid_busy", tx_busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_count", rx_count, 0);
        check("mid_rst_valid", rx_valid, 0);
        step(3);
        reset_n = 1'b1;
        step(3);
        loopback = 1'b1;
        step(3);
        send_tx(8'hC3, busy, bits);
        check("post_rst_busy_len", busy, 176);
        check("post_rst_bits", bits, {1'b1, 1'b0, 8'hC3, 1'b0});
        step(2);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'hC3);
        check("post_rst_flags", {parity_error, stop_bit_error, overrun}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_param_core.md
# uart_param_core

Parametrised UART transceiver: next generation of the team's fixed 8-bit UART, with configurable data width, parity mode, stop-bit count, two selectable baud divisors, an internal loopback, and a first-word-fall-through receive FIFO with overrun detection. It sits between the board pins (tx/rx) and user logic such as the BCD/seven-segment display path. The FPGA top instantiates it, inverting the board reset button to drive reset_n.

## Interface
- DATA_BITS, 8: payload bits per frame, 5..9, sent LSB first.
- PARITY_EN, 1: 1 = parity bit after data; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: 1 or 2.
- CLKS_PER_BIT_0, 5208: clock cycles per bit when baud_sel=0; even, ≥4.
- CLKS_PER_BIT_1, 434: clock cycles per bit when baud_sel=1; even, ≥4.
- FIFO_DEPTH, 8: RX FIFO entries; power of 2, ≥2.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- baud_sel  in  1  divisor select; latched independently by TX and RX at each frame start.
- loopback  in  1  1 = RX input taken from internal tx line; external rx ignored; tx pin still driven.
- tx_start  in  1  request to send tx_data; honoured only when tx_busy=0.
- tx_data  in  DATA_BITS  payload; captured on the accepting cycle.
- tx_busy  out  1  high from the cycle after acceptance until the last stop bit ends.
- tx  out  1  serial output; idle high.
- rx  in  1  serial input; asynchronous to clock.
- rx_data  out  DATA_BITS  FIFO head; valid when rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_rd  in  1  pop the FIFO head; ignored when empty.
- rx_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- parity_error  out  1  result for the last completed frame.
- stop_bit_error  out  1  result for the last completed frame.
- overrun  out  1  sticky; set when a frame is dropped because the FIFO is full.
- baud_rate  out  2  2'b01 when baud_sel=0, 2'b10 when baud_sel=1; for LEDs.

## Operation
- TX FSM: IDLE → START → DATA → PARITY (skipped if PARITY_EN=0) → STOP → IDLE.
  - Each state bit lasts N cycles, where N is the divisor latched at acceptance.
  - DATA runs DATA_BITS bits; STOP runs STOP_BITS bits, driven high.
  - The parity bit is the XOR of the data bits, inverted when PARITY_ODD=1.
- RX input: two-flop synchroniser, then falling-edge detect while in IDLE.
- RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
  - START waits N/2 cycles and re-samples. If the line is high, the edge is treated as a glitch and the FSM returns to IDLE with no error.
  - Each later bit is sampled N cycles after the previous sample (mid-bit).
  - Only the first stop bit is checked. The FSM returns to IDLE right after that sample, so back-to-back frames are accepted.
- At the stop-bit sample:
  - parity_error ← parity mismatch.
  - stop_bit_error ← stop bit sampled low.
  - Both flags hold until the next frame completes.
  - The frame is written to the FIFO even when errored.
- FIFO write when full: the frame is dropped, overrun ← 1, and FIFO contents are unchanged. overrun clears on the first accepted rx_rd.
- Simultaneous write and rx_rd when full: the pop is applied first, the write is accepted, and rx_count is unchanged.
- Simultaneous write and rx_rd when not full: both are performed and rx_count is unchanged.
- Changing baud_sel or loopback mid-frame has no effect on the frame in progress. Loopback takes effect only while the RX FSM is in IDLE.

## Timing
- Reset values:
  - tx = 1; tx_busy = 0; rx_valid = 0; rx_count = 0.
  - rx_data = 0; parity_error = 0; stop_bit_error = 0; overrun = 0.
  - Both FSMs in IDLE; FIFO pointers = 0.
  - baud_rate follows baud_sel combinationally.
- TX acceptance: tx_start=1 with tx_busy=0 in cycle k.
  - tx_busy=1 and tx=0 from cycle k+1.
  - Frame length F = N·(1 + DATA_BITS + PARITY_EN + STOP_BITS) cycles.
  - tx_busy falls at k+1+F, and a new tx_start is accepted in that same cycle.
- RX latency: rx_valid rises 1 cycle after the stop-bit sample. That sample falls about 2 + N·(DATA_BITS+PARITY_EN+1.5) cycles after the rx falling edge.
- rx_rd in cycle k: rx_data and rx_count update at k+1.
- Reset asserted mid-frame: both FSMs abort immediately, and tx is forced high asynchronously. The partial frame is lost and the FIFO is emptied.

## Test plan
- Default parameters except CLKS_PER_BIT_1=16, baud_sel=1, loopback=1; send 8'hA5 → tx_busy=1 for 176 cycles; rx_data=8'hA5, rx_valid=1, both error flags 0.
- External rx driven with 8'h3C and a wrong parity bit (even mode) → parity_error=1; 8'h3C stored; a following clean frame clears parity_error.
- External rx frame with its stop bit held low → stop_bit_error=1; the next valid frame clears it.
- FIFO_DEPTH=4: nine frames arrive with no reads → rx_count=4, overrun=1, the first four bytes are retained in order; one rx_rd → overrun=0, rx_count=3.
- 3-cycle low glitch on rx (N=16) → no FIFO write and no error flags.
- Assert reset_n=0 during the DATA state of a TX frame → tx=1, tx_busy=0, rx_count=0 immediately; a new frame after release transmits correctly.
